// File: rtl/xadc_drp_scheduler.sv
// rtl/xadc_drp_scheduler.sv - XADC DRP scan scheduler for the EMG (VAUX3) and ECG (VAUX11) channels
// Optional 4-sample per-channel averaging is built in when XADC_SCHED_AVG_EN is defined.
module xadc_drp_scheduler #(
    parameter int SAMPLE_DIV     = 50000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  ch_mask,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] emg_data,
    output logic        emg_valid,
    output logic [11:0] ecg_data,
    output logic        ecg_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] ADDR_EMG = 7'h13;
    localparam logic [6:0] ADDR_ECG = 7'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             pending;
    logic             rr_ecg;
    logic             sel_ecg;
    logic             sel_ecg_nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic             start;
    logic             rsp;
    logic             tmo;
    logic             smp_ready;
    logic [11:0]      smp_value;
    logic             unused_do_lsbs;

    assign drp_dwe        = 1'b0;
    assign drp_di         = 16'h0000;
    assign drp_den        = (state == ST_ISSUE);
    assign busy           = (state != ST_IDLE);
    assign unused_do_lsbs = ^drp_do[3:0];

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_ecg_nxt = sel_ecg;
        start       = 1'b0;
        rsp         = 1'b0;
        tmo         = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((tick || pending) && enable && (ch_mask != 2'b00)) begin
                    start     = 1'b1;
                    state_nxt = ST_ISSUE;
                    case (ch_mask)
                        2'b01:   sel_ecg_nxt = 1'b0;
                        2'b10:   sel_ecg_nxt = 1'b1;
                        default: sel_ecg_nxt = rr_ecg;
                    endcase
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (drp_drdy) begin
                    rsp       = 1'b1;
                    state_nxt = ST_STORE;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_STORE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Channel choice and address are latched only on IDLE->ISSUE, so they stay
    // put for the whole transaction even if ch_mask moves underneath.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            rr_ecg      <= 1'b0;
            sel_ecg     <= 1'b0;
            drp_daddr   <= ADDR_EMG;
            wait_cnt    <= '0;
        end else begin
            sel_ecg <= sel_ecg_nxt;
            if (start) begin
                pending   <= 1'b0;
                rr_ecg    <= ~sel_ecg_nxt;
                drp_daddr <= sel_ecg_nxt ? ADDR_ECG : ADDR_EMG;
            end else if (tick && busy) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef XADC_SCHED_AVG_EN
    logic [13:0] emg_acc;
    logic [13:0] ecg_acc;
    logic [13:0] acc_next;
    logic [1:0]  emg_cnt;
    logic [1:0]  ecg_cnt;
    logic [1:0]  cnt_cur;

    assign acc_next  = (sel_ecg ? ecg_acc : emg_acc) + {2'b00, drp_do[15:4]};
    assign cnt_cur   = sel_ecg ? ecg_cnt : emg_cnt;
    assign smp_ready = rsp && (cnt_cur == 2'd3);
    assign smp_value = acc_next[13:2];

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            emg_acc <= '0;
            ecg_acc <= '0;
            emg_cnt <= '0;
            ecg_cnt <= '0;
        end else if (rsp) begin
            if (sel_ecg) begin
                ecg_acc <= (cnt_cur == 2'd3) ? 14'd0 : acc_next;
                ecg_cnt <= cnt_cur + 2'd1;
            end else begin
                emg_acc <= (cnt_cur == 2'd3) ? 14'd0 : acc_next;
                emg_cnt <= cnt_cur + 2'd1;
            end
        end
    end
`else
    assign smp_ready = rsp;
    assign smp_value = drp_do[15:4];
`endif

    // Results register on the drdy edge, so valid is high exactly in STORE.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            emg_data  <= '0;
            ecg_data  <= '0;
            emg_valid <= 1'b0;
            ecg_valid <= 1'b0;
        end else begin
            emg_valid <= 1'b0;
            ecg_valid <= 1'b0;
            if (smp_ready) begin
                if (sel_ecg) begin
                    ecg_data  <= smp_value;
                    ecg_valid <= 1'b1;
                end else begin
                    emg_data  <= smp_value;
                    emg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// tb/tb_xadc_drp_scheduler.sv - scoreboard bench for xadc_drp_scheduler
// Expectations switch with XADC_SCHED_AVG_EN.
module tb_xadc_drp_scheduler;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic        enable;
    logic [1:0]  ch_mask;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [11:0] emg_data;
    logic        emg_valid;
    logic [11:0] ecg_data;
    logic        ecg_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun;

    logic        o_enable;
    logic [1:0]  o_mask;
    logic [6:0]  o_daddr;
    logic        o_den;
    logic        o_dwe;
    logic [15:0] o_di;
    logic [15:0] o_do;
    logic        o_drdy;
    logic [11:0] o_emg_data;
    logic        o_emg_valid;
    logic [11:0] o_ecg_data;
    logic        o_ecg_valid;
    logic        o_busy;
    logic        o_timeout_err;
    logic        o_overrun;

    always #5 CLK100MHZ = ~CLK100MHZ;

    xadc_drp_scheduler #(.SAMPLE_DIV(20), .TIMEOUT_CYCLES(8)) u_dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .emg_data(emg_data), .emg_valid(emg_valid), .ecg_data(ecg_data), .ecg_valid(ecg_valid),
        .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
    );

    xadc_drp_scheduler #(.SAMPLE_DIV(4), .TIMEOUT_CYCLES(255)) u_ovr (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(o_enable), .ch_mask(o_mask),
        .drp_daddr(o_daddr), .drp_den(o_den), .drp_dwe(o_dwe), .drp_di(o_di),
        .drp_do(o_do), .drp_drdy(o_drdy),
        .emg_data(o_emg_data), .emg_valid(o_emg_valid), .ecg_data(o_ecg_data), .ecg_valid(o_ecg_valid),
        .busy(o_busy), .timeout_err(o_timeout_err), .overrun(o_overrun)
    );

    typedef struct {
        int          delay;
        logic [15:0] data;
    } resp_t;

    resp_t       resp_q[$];
    logic [6:0]  exp_addr[$];
    logic [12:0] exp_val[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_drdy_cyc = -100;
    int          mdl_acc[2];
    int          mdl_cnt[2];

    always @(posedge CLK100MHZ) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mdl_acc[i] = 0;
            mdl_cnt[i] = 0;
        end
    endtask

    task automatic push_sample(input int ch, input logic [11:0] s);
`ifdef XADC_SCHED_AVG_EN
        mdl_acc[ch] += int'(s);
        mdl_cnt[ch]++;
        if (mdl_cnt[ch] == 4) begin
            exp_val.push_back({ch[0], 12'(mdl_acc[ch] >> 2)});
            mdl_acc[ch] = 0;
            mdl_cnt[ch] = 0;
        end
`else
        exp_val.push_back({ch[0], s});
`endif
    endtask

    task automatic txn(input int ch, input int delay, input logic [15:0] d16, input logic [11:0] d12);
        resp_t r;
        r.delay = delay;
        r.data  = d16;
        exp_addr.push_back((ch == 1) ? 7'h1B : 7'h13);
        resp_q.push_back(r);
        push_sample(ch, d12);
    endtask

    task automatic mon_valid(input bit ch, input logic [11:0] d);
        logic [12:0] e;
        if (exp_val.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid_unexpected: got ch%0d data %0h expected no valid", ch, d);
        end else begin
            e = exp_val.pop_front();
            check("valid_ch", 32'(ch), 32'(e[12]));
            check("valid_data", 32'(d), 32'(e[11:0]));
            check("valid_latency", cyc, last_drdy_cyc + 1);
            check("valid_daddr", 32'(drp_daddr), ch ? 32'h1B : 32'h13);
        end
    endtask

    // Monitor: every DRP request and every valid pulse is matched against the queues.
    always @(negedge CLK100MHZ) begin
        logic [6:0] a;
        if (!reset) begin
            if (drp_den) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL den_unexpected: got daddr %0h expected no request", drp_daddr);
                end else begin
                    a = exp_addr.pop_front();
                    check("daddr", 32'(drp_daddr), 32'(a));
                end
            end
            if (emg_valid) mon_valid(1'b0, emg_data);
            if (ecg_valid) mon_valid(1'b1, ecg_data);
        end
    end

    // DRP responder for u_dut: answers each den from resp_q after the queued delay.
    initial begin
        resp_t r;
        forever begin
            @(negedge CLK100MHZ);
            if (drp_den && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (r.delay) @(negedge CLK100MHZ);
                drp_do        = r.data;
                drp_drdy      = 1'b1;
                last_drdy_cyc = cyc;
                @(negedge CLK100MHZ);
                drp_drdy = 1'b0;
            end
        end
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(exp_addr.size() == 0 && !busy) && n < budget) begin
            @(negedge CLK100MHZ);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d requests outstanding expected 0", name, exp_addr.size());
        end
    endtask

    task automatic wait_den(input string name, input int budget, input bit use_ovr);
        int n = 0;
        do begin
            @(negedge CLK100MHZ);
            n++;
        end while (!(use_ovr ? o_den : drp_den) && n < budget);
        if (!(use_ovr ? o_den : drp_den)) begin
            checks++;
            errors++;
            $display("FAIL %s_den: got no den expected den within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_den"}, 32'(drp_den), 0);
        check({tag, "_daddr"}, 32'(drp_daddr), 32'h13);
        check({tag, "_emg_data"}, 32'(emg_data), 0);
        check({tag, "_ecg_data"}, 32'(ecg_data), 0);
        check({tag, "_valids"}, {30'd0, emg_valid, ecg_valid}, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        enable   = 1'b0;
        ch_mask  = 2'b00;
        drp_do   = 16'h0000;
        drp_drdy = 1'b0;
        o_enable = 1'b0;
        o_mask   = 2'b01;
        o_do     = 16'h0000;
        o_drdy   = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK100MHZ);
        check_reset_values("rst");
        check("rst_dwe_di", {15'd0, drp_dwe, drp_di}, 0);

        // Both channels: EMG first, then alternate
        ch_mask = 2'b11;
        for (int i = 0; i < 4; i++) txn(i % 2, 3, 16'hABC0, 12'hABC);
        enable = 1'b1;
        reset  = 1'b0;
        drain("rr", 300);
        enable = 1'b0;
        check("rr_vals_left", exp_val.size(), 0);

        // ECG only
        ch_mask = 2'b10;
        for (int i = 0; i < 2; i++) txn(1, 3, 16'h5550, 12'h555);
        enable = 1'b1;
        drain("ecg_only", 200);
        enable = 1'b0;
        check("ecg_only_vals_left", exp_val.size(), 0);
        check("pre_tmo_timeout_err", 32'(timeout_err), 0);
        check("pre_tmo_overrun", 32'(overrun), 0);

        // No drdy: 8 WAIT cycles then IDLE with timeout_err
        ch_mask = 2'b01;
        exp_addr.push_back(7'h13);
        enable = 1'b1;
        wait_den("tmo", 100, 1'b0);
        enable = 1'b0;
        repeat (8) @(negedge CLK100MHZ);
        check("tmo_busy_last_wait", 32'(busy), 1);
        check("tmo_err_before", 32'(timeout_err), 0);
        @(negedge CLK100MHZ);
        check("tmo_busy_idle", 32'(busy), 0);
        check("tmo_err", 32'(timeout_err), 1);

        // Reset in WAIT, drdy arrives 2 cycles later into an idle FSM
        exp_addr.push_back(7'h13);
        begin
            resp_t r;
            r.delay = 4;
            r.data  = 16'hFFF0;
            resp_q.push_back(r);
        end
        enable = 1'b1;
        wait_den("rst_wait", 100, 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        check("rst_wait_busy", 32'(busy), 1);
        reset = 1'b1;
        model_reset();
        @(negedge CLK100MHZ);
        reset = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        check_reset_values("rst_mid");
        check("rst_mid_vals_left", exp_val.size(), 0);

        // EMG sequence 100..400
        ch_mask = 2'b01;
        txn(0, 3, 16'h1000, 12'h100);
        txn(0, 2, 16'h2000, 12'h200);
        txn(0, 5, 16'h3000, 12'h300);
        txn(0, 1, 16'h4000, 12'h400);
        enable = 1'b1;
        drain("emg_seq", 300);
        enable = 1'b0;
        check("emg_seq_vals_left", exp_val.size(), 0);
`ifdef XADC_SCHED_AVG_EN
        check("emg_last", 32'(emg_data), 32'h280);
        repeat (30) @(negedge CLK100MHZ);
        check("emg_hold", 32'(emg_data), 32'h280);
`else
        check("emg_last", 32'(emg_data), 32'h400);
        repeat (30) @(negedge CLK100MHZ);
        check("emg_hold", 32'(emg_data), 32'h400);
`endif
        check("ecg_untouched", 32'(ecg_data), 0);

        // Overrun: SAMPLE_DIV=4 instance with drdy held off 10 cycles
        o_enable = 1'b1;
        wait_den("ovr", 50, 1'b1);
        o_enable = 1'b0;
        check("ovr_daddr", 32'(o_daddr), 32'h13);
        repeat (5) @(negedge CLK100MHZ);
        check("ovr_busy", 32'(o_busy), 1);
        check("ovr_early", 32'(o_overrun), 0);
        repeat (4) @(negedge CLK100MHZ);
        check("ovr_set", 32'(o_overrun), 1);
        @(negedge CLK100MHZ);
        o_do   = 16'h1230;
        o_drdy = 1'b1;
        @(negedge CLK100MHZ);
        o_drdy = 1'b0;
`ifdef XADC_SCHED_AVG_EN
        check("ovr_valid", 32'(o_emg_valid), 0);
`else
        check("ovr_valid", 32'(o_emg_valid), 1);
        check("ovr_data", 32'(o_emg_data), 32'h123);
`endif
        repeat (2) @(negedge CLK100MHZ);
        check("ovr_idle", 32'(o_busy), 0);
        check("ovr_timeout_err", 32'(o_timeout_err), 0);

        repeat (5) @(negedge CLK100MHZ);
        check("end_addr_left", exp_addr.size(), 0);
        check("end_vals_left", exp_val.size(), 0);
        check("end_resp_left", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
